fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Parametrised program-counter unit for the IF stage. It holds the fetch PC and selects the next PC from, in priority order: exception redirect, EX-stage redirect, stall, a direct-mapped branch target buffer (BTB) prediction, and sequential increment. The BTB is trained by branch resolutions from EX. `pred_taken`/`pred_target` accompany the fetched PC down the pipeline so EX can detect mispredicts.

## Interface
- WIDTH, 32, address width in bits (≥ 8)
- PC_BASE, 32'h0000_3000, PC value after reset
- BTB_DEPTH, 16, BTB entries (power of 2, ≥ 2)
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- stall_f  input  1  hold PC (load-use or I-cache stall)
- exc_valid  input  1  exception/ERET redirect request
- exc_target  input  WIDTH  exception/ERET target
- redir_valid  input  1  EX mispredict redirect request
- redir_target  input  WIDTH  corrected PC
- upd_valid  input  1  branch resolved in EX; train BTB
- upd_pc  input  WIDTH  PC of the resolved branch
- upd_target  input  WIDTH  resolved taken target
- upd_taken  input  1  branch outcome
- pc  output  WIDTH  current fetch PC (registered)
- pred_taken  output  1  BTB predicts taken for `pc`
- pred_target  output  WIDTH  predicted target for `pc`; equals pc+4 when not taken

## Operation
- Let IDX = log2(BTB_DEPTH). Index = pc[IDX+1:2]; tag = pc[WIDTH-1:IDX+2].
- Each BTB entry holds a valid bit, a tag, a target and a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is combinational on the registered `pc`. A hit requires valid and a tag match. `pred_taken` = hit && counter[1].
- Next-PC priority:
  1. !rst → PC_BASE
  2. exc_valid → exc_target
  3. redir_valid → redir_target
  4. stall_f → pc (hold)
  5. pred_taken → BTB target
  6. otherwise → pc+4
- Every value loaded into `pc` has bits [1:0] forced to 0. pc+4 wraps modulo 2^WIDTH (0xFFFF_FFFC → 0x0000_0000).
- BTB update on upd_valid, at the index of upd_pc:
  - Hit, taken: counter incremented (saturates at 11); target ← upd_target.
  - Hit, not taken: counter decremented (saturates at 00); target unchanged.
  - Miss, taken: allocate/overwrite the entry: valid=1, new tag, target=upd_target, counter=10.
  - Miss, not taken: no change.
- Updates are independent of stall_f, exc_valid and redir_valid.

## Timing
- Reset (rst=0 at a posedge):
  - pc=PC_BASE.
  - All BTB valid bits and counters cleared.
  - Hence pred_taken=0 and pred_target=PC_BASE+4 in the first cycle after reset.
- Reset asserted mid-operation overrides every other input that cycle, including upd_valid.
- Redirects and stalls take effect at the next posedge: `pc` shows the new value one cycle after the request is sampled. No bubble is inserted internally; flushing is the pipeline's job.
- The BTB write happens at the posedge. A lookup of the same index in the same cycle sees the pre-update contents; the updated entry is visible from the next cycle.
- exc_valid and redir_valid both high: exception wins. Either one with stall_f: the redirect wins, so stall never suppresses a redirect.
- pred_taken/pred_target are combinational from `pc` and the BTB state; they carry no extra latency.

## Structure
- Shared package `fetch_pkg`:
  - 2-bit counter encodings and the reset counter value.
  - BTB entry struct {valid, tag, target, ctr}, parameterised via WIDTH/IDX localparams.
  - PC_BASE default, shared with the rest of the core.
- One sub-module, `btb_dm`: storage, lookup and update logic. It exposes a lookup port (pc → hit, taken, target) and an update port. `fetch_pc_unit` contains the PC register and the next-PC mux.

## Test plan
- Reset, then release with no other inputs: pc = 0x3000, 0x3004, 0x3008 on successive cycles; pred_taken=0 throughout.
- stall_f high for 3 cycles at pc=0x3008: pc stays 0x3008 for 3 cycles, then 0x300C. Repeat with redir_valid=1, redir_target=0x3100 asserted during the stall: next pc=0x3100.
- exc_valid (target 0x4180) and redir_valid (target 0x3100) in the same cycle: next pc=0x4180. A redir_target of 0x3103 loads as 0x3100.
- upd_valid: upd_pc=0x3010, upd_target=0x3200, taken. When pc later reaches 0x3010: pred_taken=1, pred_target=0x3200, next pc=0x3200. Two not-taken updates on the same entry (10→01→00): pred_taken=0 and next pc=0x3014.
- Aliasing: train 0x3010 taken, then train 0x3050 taken (same index at DEPTH=16, different tag). A lookup at 0x3010 misses (pred_taken=0); a lookup at 0x3050 hits with its own target.
- Update and lookup of the same entry in the same cycle: the prediction uses the old entry, the new entry applies the next cycle. pc=0xFFFF_FFFC with no redirect: next pc=0x0000_0000. Reset during an active update: BTB ends fully invalid.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: BTB counter encodings, BTB entry layout, reset PC.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package fetch_pkg;

  // Default configuration shared with the rest of the core.
  localparam int unsigned FETCH_WIDTH   = 32;
  localparam int unsigned BTB_DEPTH_DEF = 16;
  localparam int unsigned BTB_IDX       = $clog2(BTB_DEPTH_DEF);
  localparam int unsigned BTB_TAG_W     = FETCH_WIDTH - BTB_IDX - 2;
  localparam logic [31:0] PC_BASE_DEF   = 32'h0000_3000;

  // 2-bit saturating direction counter; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = CTR_SNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

  // BTB entry layout for the default configuration.
  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_W-1:0]   tag;
    logic [FETCH_WIDTH-1:0] target;
    ctr_t                   ctr;
  } btb_entry_t;

  // Saturating step of the direction counter toward the resolved outcome.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    case (c)
      CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_btb.sv
// btb_dm: direct-mapped branch target buffer with 2-bit counters.
// Latency: lookup combinational; update written at posedge, visible next cycle.
// Backpressure: none; one lookup and one update accepted every cycle.
// Ports: clk/rst (sync, active-low) | lkp_addr_i (word address) -> lkp_hit_o,
//        lkp_taken_o (counter MSB), lkp_target_o | upd_vld_i, upd_addr_i,
//        upd_target_i, upd_taken_i.
module btb_dm
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-3:0] lkp_addr_i,
  output logic             lkp_hit_o,
  output logic             lkp_taken_o,
  output logic [WIDTH-1:0] lkp_target_o,
  input  logic             upd_vld_i,
  input  logic [WIDTH-3:0] upd_addr_i,
  input  logic [WIDTH-1:0] upd_target_i,
  input  logic             upd_taken_i
);

  localparam int unsigned IDX   = $clog2(DEPTH);
  localparam int unsigned TAG_W = WIDTH - 2 - IDX;

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [WIDTH-1:0]  target_q [DEPTH];
  ctr_t              ctr_q    [DEPTH];

  logic [IDX-1:0]    lkp_idx, upd_idx;
  logic [TAG_W-1:0]  lkp_tag, upd_tag;
  logic              upd_hit;

  assign lkp_idx = lkp_addr_i[IDX-1:0];
  assign lkp_tag = lkp_addr_i[WIDTH-3:IDX];
  assign upd_idx = upd_addr_i[IDX-1:0];
  assign upd_tag = upd_addr_i[WIDTH-3:IDX];

  assign lkp_hit_o    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign lkp_taken_o  = ctr_q[lkp_idx][1];
  assign lkp_target_o = target_q[lkp_idx];

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Tags/targets are not reset: they are meaningless while valid is clear.
  // Reset still blocks the update so an in-flight training cannot survive it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= CTR_RESET;
      end
    end else if (upd_vld_i) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken_i);
        if (upd_taken_i) begin
          target_q[upd_idx] <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        // Miss + taken: allocate over whatever aliased there.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
        ctr_q[upd_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage PC register and next-PC selection with BTB prediction.
// Latency: redirect/stall visible on pc one cycle after sampling; prediction combinational.
// Backpressure: stall_f holds pc; exception/EX redirects override stall.
// Ports: clk, rst (sync, active-low) | stall_f | exc_valid/exc_target |
//        redir_valid/redir_target | upd_valid/upd_pc/upd_target/upd_taken |
//        pc, pred_taken, pred_target.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] PC_BASE   = WIDTH'(PC_BASE_DEF),
  parameter int unsigned      BTB_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_target,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic [WIDTH-1:0] upd_target,
  input  logic             upd_taken,
  output logic [WIDTH-1:0] pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target
);

  logic [WIDTH-1:0] pc_q, pc_d, pc_sel, pc_seq;
  logic             btb_hit, btb_taken;
  logic [WIDTH-1:0] btb_target;
  logic             upd_pc_unused;

  // Branch PCs are word aligned; the low bits carry no index/tag information.
  assign upd_pc_unused = ^upd_pc[1:0];

  btb_dm #(
    .WIDTH (WIDTH),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lkp_addr_i   (pc_q[WIDTH-1:2]),
    .lkp_hit_o    (btb_hit),
    .lkp_taken_o  (btb_taken),
    .lkp_target_o (btb_target),
    .upd_vld_i    (upd_valid),
    .upd_addr_i   (upd_pc[WIDTH-1:2]),
    .upd_target_i (upd_target),
    .upd_taken_i  (upd_taken)
  );

  // Wraps naturally modulo 2^WIDTH.
  assign pc_seq = pc_q + WIDTH'(4);

  assign pred_taken  = btb_hit && btb_taken;
  assign pred_target = pred_taken ? btb_target : pc_seq;
  assign pc          = pc_q;

  always_comb begin
    pc_sel = pc_seq;
    if (exc_valid) begin
      pc_sel = exc_target;
    end else if (redir_valid) begin
      pc_sel = redir_target;
    end else if (stall_f) begin
      pc_sel = pc_q;
    end else if (pred_taken) begin
      pc_sel = btb_target;
    end
    // Fetch is word aligned regardless of where the target came from.
    pc_d = {pc_sel[WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= {PC_BASE[WIDTH-1:2], 2'b00};
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDX   = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        exc_valid;
  logic [31:0] exc_target;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .WIDTH     (32),
    .PC_BASE   (BASE),
    .BTB_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_f      (stall_f),
    .exc_valid    (exc_valid),
    .exc_target   (exc_target),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .pc           (pc),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: the BTB as plain arrays of entries, counter as an integer 0..3.
  bit          m_v   [DEPTH];
  int unsigned m_tag [DEPTH];
  int unsigned m_tgt [DEPTH];
  int          m_ctr [DEPTH];
  int unsigned m_pc;

  function automatic bit m_taken(input int unsigned a);
    int unsigned i;
    i = (a >> 2) % DEPTH;
    return m_v[i] && (m_tag[i] == (a >> (IDX + 2))) && (m_ctr[i] >= 2);
  endfunction

  function automatic int unsigned m_target(input int unsigned a);
    int unsigned i;
    i = (a >> 2) % DEPTH;
    return m_taken(a) ? m_tgt[i] : a + 4;
  endfunction

  // One clock: model next state from current inputs, clock the DUT, compare.
  task automatic step();
    int unsigned np, i, t;
    bit hit;
    if (!rst) begin
      np = BASE;
      for (int k = 0; k < DEPTH; k++) begin
        m_v[k]   = 1'b0;
        m_ctr[k] = 0;
      end
    end else begin
      if (exc_valid)        np = exc_target;
      else if (redir_valid) np = redir_target;
      else if (stall_f)     np = m_pc;
      else                  np = m_target(m_pc);
      if (upd_valid) begin
        i   = (upd_pc >> 2) % DEPTH;
        t   = upd_pc >> (IDX + 2);
        hit = m_v[i] && (m_tag[i] == t);
        if (hit && upd_taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = upd_target;
        end else if (hit) begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end else if (upd_taken) begin
          m_v[i]   = 1'b1;
          m_tag[i] = t;
          m_tgt[i] = upd_target;
          m_ctr[i] = 2;
        end
      end
    end
    np = np & 32'hFFFF_FFFC;
    @(posedge clk);
    m_pc = np;
    @(negedge clk);
    chk("pc", pc, m_pc);
    chk("pred_taken", {31'b0, pred_taken}, {31'b0, m_taken(m_pc)});
    chk("pred_target", pred_target, m_target(m_pc));
  endtask

  task automatic idle();
    stall_f      = 1'b0;
    exc_valid    = 1'b0;
    exc_target   = '0;
    redir_valid  = 1'b0;
    redir_target = '0;
    upd_valid    = 1'b0;
    upd_pc       = '0;
    upd_target   = '0;
    upd_taken    = 1'b0;
  endtask

  task automatic redir(input logic [31:0] a);
    idle();
    redir_valid  = 1'b1;
    redir_target = a;
  endtask

  task automatic train(input logic [31:0] a, input logic [31:0] tgt, input logic tk);
    idle();
    upd_valid  = 1'b1;
    upd_pc     = a;
    upd_target = tgt;
    upd_taken  = tk;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h3000 + 32'($urandom_range(0, 511));
  endfunction

  initial begin
    rst = 1'b0;
    idle();
    @(negedge clk);

    // Reset and sequential fetch
    step();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
    chk("rst_pred_target", pred_target, 32'h3004);
    rst = 1'b1;
    step(); chk("seq1", pc, 32'h3004);
    step(); chk("seq2", pc, 32'h3008);

    // Stall, then redirect during stall
    stall_f = 1'b1;
    repeat (3) begin step(); chk("stall_hold", pc, 32'h3008); end
    stall_f = 1'b0;
    step(); chk("stall_release", pc, 32'h300C);
    redir(32'h3100); stall_f = 1'b1;
    step(); chk("redir_over_stall", pc, 32'h3100);

    // Exception beats redirect; redirect target alignment
    redir(32'h3100); exc_valid = 1'b1; exc_target = 32'h4180;
    step(); chk("exc_priority", pc, 32'h4180);
    redir(32'h3103);
    step(); chk("align", pc, 32'h3100);

    // Train taken, then follow the prediction
    train(32'h3010, 32'h3200, 1'b1); redir_valid = 1'b1; redir_target = 32'h3008;
    step(); chk("train_redir", pc, 32'h3008);
    idle();
    step(); step();
    chk("bp_pc", pc, 32'h3010);
    chk("bp_taken", {31'b0, pred_taken}, 32'd1);
    chk("bp_target", pred_target, 32'h3200);
    step(); chk("bp_follow", pc, 32'h3200);

    // Two not-taken updates: 10 -> 01 -> 00
    train(32'h3010, 32'h0, 1'b0); redir_valid = 1'b1; redir_target = 32'h3010;
    step(); chk("nt1_taken", {31'b0, pred_taken}, 32'd0);
    train(32'h3010, 32'h0, 1'b0);
    step(); chk("nt2_seq", pc, 32'h3014);

    // Same-cycle update and lookup uses old contents
    redir(32'h3020);
    step();
    train(32'h3020, 32'h3300, 1'b1);
    step(); chk("same_cycle_old", pc, 32'h3024);
    redir(32'h3020);
    step();
    chk("same_cycle_new", {31'b0, pred_taken}, 32'd1);
    chk("same_cycle_tgt", pred_target, 32'h3300);

    // Aliasing at the same index with a different tag
    train(32'h3010, 32'h3200, 1'b1); step();
    train(32'h3010, 32'h3200, 1'b1); step();
    train(32'h3050, 32'h3500, 1'b1); step();
    redir(32'h3010);
    step(); chk("alias_miss", {31'b0, pred_taken}, 32'd0);
    redir(32'h3050);
    step();
    chk("alias_hit", {31'b0, pred_taken}, 32'd1);
    chk("alias_tgt", pred_target, 32'h3500);

    // Wrap at the top of the address space
    redir(32'hFFFF_FFFC);
    step(); chk("wrap_pre", pc, 32'hFFFF_FFFC);
    idle();
    step(); chk("wrap", pc, 32'h0000_0000);

    // Reset during an active update leaves the BTB invalid
    rst = 1'b0;
    train(32'h3000, 32'h3400, 1'b1);
    step(); chk("rst_upd_taken", {31'b0, pred_taken}, 32'd0);
    rst = 1'b1;
    redir(32'h3050);
    step(); chk("rst_clears_btb", {31'b0, pred_taken}, 32'd0);
    redir(32'h3020);
    step(); chk("rst_clears_btb2", {31'b0, pred_taken}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) != 0);
      exc_valid    = ($urandom_range(0, 19) == 0);
      exc_target   = rand_addr();
      redir_valid  = ($urandom_range(0, 9) == 0);
      redir_target = rand_addr();
      stall_f      = ($urandom_range(0, 4) == 0);
      upd_valid    = ($urandom_range(0, 2) == 0);
      upd_pc       = rand_addr() & 32'hFFFF_FFFC;
      upd_target   = rand_addr();
      upd_taken    = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
